decode_stage: RTL and testbench



---
 rtl/decode_stage.sv | 227 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I instruction decoder feeding a 2-entry skid buffer.
// Optional M-extension decode is enabled by defining DECODE_MEXT_EN.
module decode_stage #(
  parameter int XLEN    = 32,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [XLEN-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [5:0]         out_op,
  output logic [XLEN-1:0]    out_imm,
  output logic [4:0]         out_rd,
  output logic [4:0]         out_rs1,
  output logic [4:0]         out_rs2,
  output logic               out_valid_rd,
  output logic               out_valid_rs1,
  output logic               out_valid_rs2,
  output logic               out_valid_imm,
  output logic               out_illegal,
  output logic [COUNT_W-1:0] illegal_count,
  input  logic               flush
);

  typedef enum logic [5:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_ILLEGAL = 6'd63
  } op_e;

  typedef enum logic [2:0] {F_R, F_I, F_S, F_B, F_U, F_J, F_SH} fmt_e;
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [5:0]      op;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd, rs1, rs2;
    logic            v_rd, v_rs1, v_rs2, v_imm;
    logic            illegal;
  } entry_t;

  logic [6:0]      w_opc, w_f7;
  logic [2:0]      w_f3;
  logic            w_shamt_ok;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;
  logic [5:0]      w_op;
  fmt_e            w_fmt;
  entry_t          w_dec;

  assign w_opc = in_instr[6:0];
  assign w_f3  = in_instr[14:12];
  assign w_f7  = in_instr[31:25];
  // On RV32 shamt is 5 bits, so bit 25 set makes a shift-immediate illegal.
  assign w_shamt_ok = (XLEN == 64) || !in_instr[25];

  assign w_imm_i  = XLEN'($signed(in_instr[31:20]));
  assign w_imm_s  = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign w_imm_b  = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign w_imm_u  = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign w_imm_j  = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
  assign w_imm_sh = XLEN'(in_instr[25:20]);

  always_comb begin
    w_op  = OP_ILLEGAL;
    w_fmt = F_R;
    case (w_opc)
      7'b0110111: begin w_op = OP_LUI;   w_fmt = F_U; end
      7'b0010111: begin w_op = OP_AUIPC; w_fmt = F_U; end
      7'b1101111: begin w_op = OP_JAL;   w_fmt = F_J; end
      7'b1100111: begin w_fmt = F_I; if (w_f3 == 3'd0) w_op = OP_JALR; end
      7'b1100011: begin
        w_fmt = F_B;
        case (w_f3)
          3'd0: w_op = OP_BEQ;  3'd1: w_op = OP_BNE;
          3'd4: w_op = OP_BLT;  3'd5: w_op = OP_BGE;
          3'd6: w_op = OP_BLTU; 3'd7: w_op = OP_BGEU;
          default: ;
        endcase
      end
      7'b0000011: begin
        w_fmt = F_I;
        case (w_f3)
          3'd0: w_op = OP_LB;  3'd1: w_op = OP_LH; 3'd2: w_op = OP_LW;
          3'd4: w_op = OP_LBU; 3'd5: w_op = OP_LHU;
          default: ;
        endcase
      end
      7'b0100011: begin
        w_fmt = F_S;
        case (w_f3)
          3'd0: w_op = OP_SB; 3'd1: w_op = OP_SH; 3'd2: w_op = OP_SW;
          default: ;
        endcase
      end
      7'b0010011: begin
        w_fmt = F_I;
        case (w_f3)
          3'd0: w_op = OP_ADDI; 3'd2: w_op = OP_SLTI; 3'd3: w_op = OP_SLTIU;
          3'd4: w_op = OP_XORI; 3'd6: w_op = OP_ORI;  3'd7: w_op = OP_ANDI;
          3'd1: begin
            w_fmt = F_SH;
            if (w_shamt_ok && w_f7[6:1] == 6'b000000) w_op = OP_SLLI;
          end
          default: begin
            w_fmt = F_SH;
            if (w_shamt_ok && w_f7[6:1] == 6'b000000) w_op = OP_SRLI;
            else if (w_shamt_ok && w_f7[6:1] == 6'b010000) w_op = OP_SRAI;
          end
        endcase
      end
      7'b0110011: begin
        w_fmt = F_R;
        if (w_f7 == 7'b0000000) begin
          case (w_f3)
            3'd0: w_op = OP_ADD; 3'd1: w_op = OP_SLL; 3'd2: w_op = OP_SLT; 3'd3: w_op = OP_SLTU;
            3'd4: w_op = OP_XOR; 3'd5: w_op = OP_SRL; 3'd6: w_op = OP_OR;  default: w_op = OP_AND;
          endcase
        end else if (w_f7 == 7'b0100000) begin
          if (w_f3 == 3'd0) w_op = OP_SUB;
          else if (w_f3 == 3'd5) w_op = OP_SRA;
        end
`ifdef DECODE_MEXT_EN
        else if (w_f7 == 7'b0000001) w_op = 6'(OP_MUL) + 6'(w_f3);
`endif
      end
      default: ;
    endcase
  end

  // Register indices pass through even for illegal entries; flags and imm stay 0.
  always_comb begin
    w_dec         = '0;
    w_dec.pc      = in_pc;
    w_dec.op      = w_op;
    w_dec.rd      = in_instr[11:7];
    w_dec.rs1     = in_instr[19:15];
    w_dec.rs2     = in_instr[24:20];
    w_dec.illegal = (w_op == OP_ILLEGAL);
    if (!w_dec.illegal) begin
      case (w_fmt)
        F_R:  begin w_dec.v_rd = 1'b1; w_dec.v_rs1 = 1'b1; w_dec.v_rs2 = 1'b1; end
        F_I:  begin w_dec.v_rd = 1'b1; w_dec.v_rs1 = 1'b1; w_dec.v_imm = 1'b1; w_dec.imm = w_imm_i; end
        F_SH: begin w_dec.v_rd = 1'b1; w_dec.v_rs1 = 1'b1; w_dec.v_imm = 1'b1; w_dec.imm = w_imm_sh; end
        F_S:  begin w_dec.v_rs1 = 1'b1; w_dec.v_rs2 = 1'b1; w_dec.v_imm = 1'b1; w_dec.imm = w_imm_s; end
        F_B:  begin w_dec.v_rs1 = 1'b1; w_dec.v_rs2 = 1'b1; w_dec.v_imm = 1'b1; w_dec.imm = w_imm_b; end
        F_U:  begin w_dec.v_rd = 1'b1; w_dec.v_imm = 1'b1; w_dec.imm = w_imm_u; end
        default: begin w_dec.v_rd = 1'b1; w_dec.v_imm = 1'b1; w_dec.imm = w_imm_j; end
      endcase
    end
  end

  state_e       r_state, w_state_nxt;
  entry_t       r_out, r_skid;
  logic         r_in_ready;
  logic [COUNT_W-1:0] r_cnt;
  logic         w_acc, w_drain, w_load_out, w_load_skid, w_skid_to_out;

  assign w_acc   = in_valid && r_in_ready;
  assign w_drain = out_valid && out_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_load_out    = 1'b0;
    w_load_skid   = 1'b0;
    w_skid_to_out = 1'b0;
    case (r_state)
      S_EMPTY: if (w_acc) begin w_state_nxt = S_ONE; w_load_out = 1'b1; end
      S_ONE: begin
        if (w_acc && w_drain) w_load_out = 1'b1;
        else if (w_acc) begin w_state_nxt = S_FULL; w_load_skid = 1'b1; end
        else if (w_drain) w_state_nxt = S_EMPTY;
      end
      S_FULL: if (w_drain) begin w_state_nxt = S_ONE; w_skid_to_out = 1'b1; end
      default: w_state_nxt = S_EMPTY;
    endcase
    if (flush) begin
      w_state_nxt   = S_EMPTY;
      w_load_out    = 1'b0;
      w_load_skid   = 1'b0;
      w_skid_to_out = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
      r_out      <= '0;
      r_skid     <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_FULL);
      if (w_load_out) r_out <= w_dec;
      else if (w_skid_to_out) r_out <= r_skid;
      if (w_load_skid) r_skid <= w_dec;
      // Counts every accepted illegal instruction, even one dropped by flush.
      if (w_acc && w_dec.illegal && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = (r_state != S_EMPTY);
  assign out_pc        = r_out.pc;
  assign out_op        = r_out.op;
  assign out_imm       = r_out.imm;
  assign out_rd        = r_out.rd;
  assign out_rs1       = r_out.rs1;
  assign out_rs2       = r_out.rs2;
  assign out_valid_rd  = r_out.v_rd;
  assign out_valid_rs1 = r_out.v_rs1;
  assign out_valid_rs2 = r_out.v_rs2;
  assign out_valid_imm = r_out.v_imm;
  assign out_illegal   = r_out.illegal;
  assign illegal_count = r_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: drives an RV32 (COUNT_W=16) and an RV64 (COUNT_W=2) decode_stage with the
// same stimulus and checks both against a mask/match instruction-table model and a queue model.
module tb_decode_stage;
`ifdef DECODE_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif
  localparam int FR = 0, FI = 1, FS = 2, FB = 3, FU = 4, FJ = 5, FSH = 6;

  logic clk, reset, in_valid, out_ready, flush;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic a_in_ready, a_valid, a_vrd, a_vrs1, a_vrs2, a_vimm, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [5:0] a_op;
  logic [4:0] a_rd, a_rs1, a_rs2;
  logic [15:0] a_cnt;
  logic b_in_ready, b_valid, b_vrd, b_vrs1, b_vrs2, b_vimm, b_ill;
  logic [63:0] b_pc, b_imm;
  logic [5:0] b_op;
  logic [4:0] b_rd, b_rs1, b_rs2;
  logic [1:0] b_cnt;

  decode_stage #(.XLEN(32), .COUNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
    .in_pc(in_pc[31:0]), .out_valid(a_valid), .out_ready(out_ready), .out_pc(a_pc), .out_op(a_op),
    .out_imm(a_imm), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_valid_rd(a_vrd),
    .out_valid_rs1(a_vrs1), .out_valid_rs2(a_vrs2), .out_valid_imm(a_vimm), .out_illegal(a_ill),
    .illegal_count(a_cnt), .flush(flush));

  decode_stage #(.XLEN(64), .COUNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .out_valid(b_valid), .out_ready(out_ready), .out_pc(b_pc), .out_op(b_op),
    .out_imm(b_imm), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_valid_rd(b_vrd),
    .out_valid_rs1(b_vrs1), .out_valid_rs2(b_vrs2), .out_valid_imm(b_vimm), .out_illegal(b_ill),
    .illegal_count(b_cnt), .flush(flush));

  wire [153:0] a_vec = {a_ill, a_op, a_vrd, a_vrs1, a_vrs2, a_vimm, a_rd, a_rs1, a_rs2,
                        32'b0, a_imm, 32'b0, a_pc};
  wire [153:0] b_vec = {b_ill, b_op, b_vrd, b_vrs1, b_vrs2, b_vimm, b_rd, b_rs1, b_rs2, b_imm, b_pc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cnt_a = 0, cnt_b = 0;
  typedef struct { logic [31:0] ins; logic [63:0] pc; } txn_t;
  txn_t q[$];

  // Instruction table indexed by op number: an instruction is op k when (ins & mask) == match.
  logic [31:0] t_mask[$], t_match[$];
  int t_fmt[$];

  task automatic ent(input logic [31:0] mask, input logic [31:0] match, input int fmt);
    t_mask.push_back(mask); t_match.push_back(match); t_fmt.push_back(fmt);
  endtask

  task automatic build_table();
    ent(32'h7F, 32'h37, FU); ent(32'h7F, 32'h17, FU); ent(32'h7F, 32'h6F, FJ); ent(32'h707F, 32'h67, FI);
    ent(32'h707F, 32'h0063, FB); ent(32'h707F, 32'h1063, FB); ent(32'h707F, 32'h4063, FB);
    ent(32'h707F, 32'h5063, FB); ent(32'h707F, 32'h6063, FB); ent(32'h707F, 32'h7063, FB);
    ent(32'h707F, 32'h0003, FI); ent(32'h707F, 32'h1003, FI); ent(32'h707F, 32'h2003, FI);
    ent(32'h707F, 32'h4003, FI); ent(32'h707F, 32'h5003, FI);
    ent(32'h707F, 32'h0023, FS); ent(32'h707F, 32'h1023, FS); ent(32'h707F, 32'h2023, FS);
    ent(32'h707F, 32'h0013, FI); ent(32'h707F, 32'h2013, FI); ent(32'h707F, 32'h3013, FI);
    ent(32'h707F, 32'h4013, FI); ent(32'h707F, 32'h6013, FI); ent(32'h707F, 32'h7013, FI);
    ent(32'hFE00707F, 32'h1013, FSH); ent(32'hFE00707F, 32'h5013, FSH); ent(32'hFE00707F, 32'h40005013, FSH);
    ent(32'hFE00707F, 32'h0033, FR); ent(32'hFE00707F, 32'h40000033, FR); ent(32'hFE00707F, 32'h1033, FR);
    ent(32'hFE00707F, 32'h2033, FR); ent(32'hFE00707F, 32'h3033, FR); ent(32'hFE00707F, 32'h4033, FR);
    ent(32'hFE00707F, 32'h5033, FR); ent(32'hFE00707F, 32'h40005033, FR); ent(32'hFE00707F, 32'h6033, FR);
    ent(32'hFE00707F, 32'h7033, FR);
    for (int f = 0; f < 8; f++) ent(32'hFE00707F, 32'h02000033 | (f << 12), FR);
  endtask

  function automatic logic [153:0] model_vec(input logic [31:0] ins, input logic [63:0] pc, input int xlen);
    int op = 63, fmt = 0;
    longint sg, imm = 0;
    logic [3:0] v = 4'b0;
    logic [31:0] m;
    logic [63:0] mk;
    for (int k = 0; k < t_mask.size(); k++) begin
      m = t_mask[k];
      if (xlen == 64 && k >= 24 && k <= 26) m[25] = 1'b0;
      if ((ins & m) == t_match[k] && (MEXT || k < 37)) begin op = k; fmt = t_fmt[k]; end
    end
    sg = ins[31] ? -1 : 0;
    if (op != 63) begin
      case (fmt)
        FR:  v = 4'b1110;
        FI:  begin v = 4'b1101; imm = sg * 2048 + longint'(ins[30:20]); end
        FSH: begin v = 4'b1101; imm = longint'(ins[25:20]); end
        FS:  begin v = 4'b0111; imm = sg * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:7]); end
        FB:  begin v = 4'b0111; imm = sg * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                                       + longint'(ins[11:8]) * 2; end
        FU:  begin v = 4'b1001; imm = sg * (longint'(1) <<< 31) + longint'(ins[30:12]) * 4096; end
        default: begin v = 4'b1001; imm = sg * 1048576 + longint'(ins[19:12]) * 4096
                                          + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2; end
      endcase
    end
    mk = (xlen == 32) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    return {op == 63, 6'(op), v, ins[11:7], ins[19:15], ins[24:20], 64'(imm) & mk, pc & mk};
  endfunction

  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                      input logic rdy, input logic fl);
    logic acc, drn;
    logic [153:0] ea, eb;
    txn_t t;
    @(negedge clk);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl;
    acc = v && (q.size() < 2);
    drn = rdy && (q.size() > 0);
    ea = model_vec(ins, pc, 32);
    eb = model_vec(ins, pc, 64);
    @(posedge clk);
    if (drn) q.delete(0);
    if (acc) begin
      t.ins = ins; t.pc = pc; q.push_back(t);
      if (ea[153] && cnt_a < 65535) cnt_a++;
      if (eb[153] && cnt_b < 3) cnt_b++;
    end
    if (fl) q.delete();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; q.delete(); cnt_a = 0; cnt_b = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (a_vec !== '0) begin n_fail++; $display("FAIL reset_a_outs: got %h want 0", a_vec); end
    n_chk++; if (b_vec !== '0) begin n_fail++; $display("FAIL reset_b_outs: got %h want 0", b_vec); end
    n_chk++; if ({a_valid, a_in_ready, b_valid, b_in_ready} !== 4'b0101) begin n_fail++;
      $display("FAIL reset_handshake: got %b want 0101", {a_valid, a_in_ready, b_valid, b_in_ready}); end
    n_chk++; if ({a_cnt, b_cnt} !== 18'd0) begin n_fail++;
      $display("FAIL reset_count: got %0d/%0d want 0/0", a_cnt, b_cnt); end
  endtask

  task automatic test_addi();
    step(1, 32'h00500093, 64'h1000, 1, 0);
    n_chk++; if ({a_valid, a_op} !== {1'b1, 6'd18}) begin n_fail++;
      $display("FAIL addi_op: got v=%b op=%0d want v=1 op=18", a_valid, a_op); end
    n_chk++; if ({a_rd, a_rs1, a_imm} !== {5'd1, 5'd0, 32'd5}) begin n_fail++;
      $display("FAIL addi_fields: got rd=%0d rs1=%0d imm=%0d want 1 0 5", a_rd, a_rs1, a_imm); end
    n_chk++; if ({a_vrd, a_vrs1, a_vrs2, a_vimm} !== 4'b1101) begin n_fail++;
      $display("FAIL addi_flags: got %b want 1101", {a_vrd, a_vrs1, a_vrs2, a_vimm}); end
    n_chk++; if (a_pc !== 32'h1000) begin n_fail++; $display("FAIL addi_pc: got %h want 1000", a_pc); end
    step(0, 0, 0, 1, 0);
    n_chk++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got v=%b want 0", a_valid); end
  endtask

  task automatic test_back_to_back();
    step(1, 32'h002081B3, 64'h2000, 1, 0);
    n_chk++; if ({a_op, a_in_ready} !== {6'd27, 1'b1}) begin n_fail++;
      $display("FAIL b2b_add: got op=%0d rdy=%b want 27 1", a_op, a_in_ready); end
    step(1, 32'h402081B3, 64'h2004, 1, 0);
    n_chk++; if ({a_op, a_in_ready, a_pc} !== {6'd28, 1'b1, 32'h2004}) begin n_fail++;
      $display("FAIL b2b_sub: got op=%0d rdy=%b pc=%h want 28 1 2004", a_op, a_in_ready, a_pc); end
    n_chk++; if ({a_rd, a_rs1, a_rs2} !== {5'd3, 5'd1, 5'd2}) begin n_fail++;
      $display("FAIL b2b_regs: got %0d %0d %0d want 3 1 2", a_rd, a_rs1, a_rs2); end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_branch64();
    step(1, 32'hFE208EE3, 64'h3000, 1, 0);
    n_chk++; if ({b_op, b_vrd} !== {6'd4, 1'b0}) begin n_fail++;
      $display("FAIL beq64_op: got op=%0d vrd=%b want 4 0", b_op, b_vrd); end
    n_chk++; if (b_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++;
      $display("FAIL beq64_imm: got %h want fffffffffffffffc", b_imm); end
    n_chk++; if (a_imm !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL beq32_imm: got %h want fffffffc", a_imm); end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_backpressure();
    step(1, 32'h00500093, 64'h4000, 0, 0);
    n_chk++; if ({a_valid, a_in_ready, a_op} !== {2'b11, 6'd18}) begin n_fail++;
      $display("FAIL bp_first: got v=%b rdy=%b op=%0d want 1 1 18", a_valid, a_in_ready, a_op); end
    step(1, 32'h002081B3, 64'h4004, 0, 0);
    n_chk++; if ({a_in_ready, b_in_ready, a_op} !== {2'b00, 6'd18}) begin n_fail++;
      $display("FAIL bp_full: got rdy=%b%b op=%0d want 00 18", a_in_ready, b_in_ready, a_op); end
    step(1, 32'h402081B3, 64'h4008, 0, 0);
    n_chk++; if ({a_in_ready, a_op, a_pc} !== {1'b0, 6'd18, 32'h4000}) begin n_fail++;
      $display("FAIL bp_hold: got rdy=%b op=%0d pc=%h want 0 18 4000", a_in_ready, a_op, a_pc); end
    step(1, 32'h402081B3, 64'h4008, 1, 0);
    n_chk++; if ({a_in_ready, a_op} !== {1'b1, 6'd27}) begin n_fail++;
      $display("FAIL bp_second: got rdy=%b op=%0d want 1 27", a_in_ready, a_op); end
    step(1, 32'h402081B3, 64'h4008, 1, 0);
    n_chk++; if ({a_op, a_pc} !== {6'd28, 32'h4008}) begin n_fail++;
      $display("FAIL bp_third: got op=%0d pc=%h want 28 4008", a_op, a_pc); end
    step(0, 0, 0, 1, 0);
    n_chk++; if ({a_valid, b_valid} !== 2'b00) begin n_fail++; $display("FAIL bp_empty: got %b want 00", {a_valid, b_valid}); end
  endtask

  task automatic test_illegal_count();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h0, 64'h5000 + i, 1, 0);
      n_chk++; if ({a_ill, a_op, a_vrd, a_vrs1, a_vrs2, a_vimm, a_imm} !== {1'b1, 6'd63, 4'b0, 32'b0}) begin
        n_fail++; $display("FAIL illegal_entry: got ill=%b op=%0d imm=%h want 1 63 0", a_ill, a_op, a_imm); end
      if (i == 2) begin
        n_chk++; if ({a_cnt, b_cnt} !== {16'd3, 2'd3}) begin n_fail++;
          $display("FAIL illegal_count3: got %0d/%0d want 3/3", a_cnt, b_cnt); end
      end
    end
    n_chk++; if ({a_cnt, b_cnt} !== {16'd5, 2'd3}) begin n_fail++;
      $display("FAIL illegal_saturate: got %0d/%0d want 5/3", a_cnt, b_cnt); end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_shift_boundary();
    step(1, 32'h02009093, 64'h6000, 1, 0);
    n_chk++; if ({a_ill, a_op, b_ill, b_op, b_imm} !== {1'b1, 6'd63, 1'b0, 6'd24, 64'd32}) begin n_fail++;
      $display("FAIL slli32: got a=%b/%0d b=%b/%0d imm=%0d want 1/63 0/24 32", a_ill, a_op, b_ill, b_op, b_imm); end
    step(1, 32'h4200D093, 64'h6004, 1, 0);
    n_chk++; if ({a_op, b_op, b_imm} !== {6'd63, 6'd26, 64'd32}) begin n_fail++;
      $display("FAIL srai32: got a=%0d b=%0d imm=%0d want 63 26 32", a_op, b_op, b_imm); end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_mext_flush();
    step(1, 32'h027302B3, 64'h7000, 1, 0);
    n_chk++; if ({a_op, a_ill, b_op} !== {MEXT ? 6'd37 : 6'd63, !MEXT, MEXT ? 6'd37 : 6'd63}) begin n_fail++;
      $display("FAIL mul_decode: got op=%0d/%0d ill=%b want mext=%b", a_op, b_op, a_ill, MEXT); end
    n_chk++; if ({a_vrd, a_vrs1, a_vrs2, a_rd} !== {MEXT ? 3'b111 : 3'b000, 5'd5}) begin n_fail++;
      $display("FAIL mul_flags: got %b%b%b rd=%0d", a_vrd, a_vrs1, a_vrs2, a_rd); end
    step(1, 32'h027302B3, 64'h7004, 1, 1);
    n_chk++; if ({a_valid, b_valid, a_in_ready} !== 3'b001) begin n_fail++;
      $display("FAIL flush_empty: got %b want 001", {a_valid, b_valid, a_in_ready}); end
    n_chk++; if (a_cnt !== 16'(cnt_a)) begin n_fail++; $display("FAIL flush_count: got %0d want %0d", a_cnt, cnt_a); end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    int k, r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = $urandom % 10;
      k = $urandom % t_mask.size();
      ins = ($urandom & ~t_mask[k]) | t_match[k];
      if (r == 6) ins[$urandom % 32] = ~ins[$urandom % 32];
      if (r == 7) ins = 32'h0;
      if (r >= 8) ins = $urandom;
      step(($urandom % 4) != 0, ins, {$urandom, $urandom}, ($urandom % 3) != 0, ($urandom % 40) == 0);
      n_chk++; if ({a_valid, a_in_ready, b_valid, b_in_ready} !==
                   {q.size() > 0, q.size() < 2, q.size() > 0, q.size() < 2}) begin n_fail++;
        $display("FAIL rand_handshake[%0d]: got %b want size %0d", i, {a_valid, a_in_ready, b_valid, b_in_ready}, q.size()); end
      if (q.size() > 0) begin
        n_chk++; if (a_vec !== model_vec(q[0].ins, q[0].pc, 32)) begin n_fail++;
          $display("FAIL rand_a[%0d] ins=%h: got %h want %h", i, q[0].ins, a_vec, model_vec(q[0].ins, q[0].pc, 32)); end
        n_chk++; if (b_vec !== model_vec(q[0].ins, q[0].pc, 64)) begin n_fail++;
          $display("FAIL rand_b[%0d] ins=%h: got %h want %h", i, q[0].ins, b_vec, model_vec(q[0].ins, q[0].pc, 64)); end
      end
      n_chk++; if ({a_cnt, b_cnt} !== {16'(cnt_a), 2'(cnt_b)}) begin n_fail++;
        $display("FAIL rand_count[%0d]: got %0d/%0d want %0d/%0d", i, a_cnt, b_cnt, cnt_a, cnt_b); end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_instr = '0; in_pc = '0;
    build_table();
    test_reset();
    test_addi();
    test_back_to_back();
    test_branch64();
    test_backpressure();
    test_illegal_count();
    test_shift_boundary();
    test_mext_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
